// File: rtl/float_add_arbiter_pkg.sv
// float_add_arbiter_pkg
//   Shared constants for the arbitrated float adder: IEEE-754 single-precision
//   field widths and the canonical quiet NaN. Imported by the top, the
//   round-robin arbiter and the adder. No ports.
package float_add_arbiter_pkg;

  localparam int FLOAT_W = 32;
  localparam int SIGN_W  = 1;
  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;

  localparam logic [EXP_W-1:0]   EXP_ALL_ONES = 8'hFF;
  localparam logic [FLOAT_W-1:0] QNAN         = 32'h7FC0_0000;

endpackage

// File: rtl/float_add_arbiter_fadd.sv
// float_add_gc
//   Combinational IEEE-754 single-precision adder, sum = a + b.
//   Rounding is toward zero (the result is chopped after exact alignment with
//   guard/round/sticky bits). Denormals are handled; overflow saturates to
//   the largest finite magnitude, as round-toward-zero requires.
//   NaN inputs or inf + (-inf) give the canonical quiet NaN.
// Ports
//   a    in   32   operand A
//   b    in   32   operand B
//   sum  out  32   a + b
module float_add_gc
  import float_add_arbiter_pkg::*;
(
  input  logic [FLOAT_W-1:0] a,
  input  logic [FLOAT_W-1:0] b,
  output logic [FLOAT_W-1:0] sum
);

  always_comb begin
    logic [EXP_W-1:0]  ea, eb, el, es, d;
    logic [FRAC_W:0]   ma, mb, ml, ms;
    logic              sl, ss, a_nan, b_nan, a_inf, b_inf;
    logic [49:0]       wide;
    logic [26:0]       aligned, norm;
    logic [27:0]       raw;
    logic [9:0]        exp_w;
    int                lz, shift;
    logic              found;

    sum     = '0;
    wide    = '0;
    aligned = '0;
    norm    = '0;
    raw     = '0;
    lz      = 0;
    shift   = 0;
    found   = 1'b0;

    a_nan = (a[30:23] == EXP_ALL_ONES) && (a[22:0] != '0);
    b_nan = (b[30:23] == EXP_ALL_ONES) && (b[22:0] != '0);
    a_inf = (a[30:23] == EXP_ALL_ONES) && (a[22:0] == '0);
    b_inf = (b[30:23] == EXP_ALL_ONES) && (b[22:0] == '0);

    // Denormals use exponent 1 with no hidden bit.
    ea = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    eb = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
    ma = {a[30:23] != 8'd0, a[22:0]};
    mb = {b[30:23] != 8'd0, b[22:0]};

    // Larger magnitude becomes the "l" operand, so the difference is never negative.
    if ({ea, ma} >= {eb, mb}) begin
      el = ea; ml = ma; sl = a[31];
      es = eb; ms = mb; ss = b[31];
    end else begin
      el = eb; ml = mb; sl = b[31];
      es = ea; ms = ma; ss = a[31];
    end

    d = el - es;
    // Align the smaller mantissa: 24 bits + guard + round + sticky.
    if (d > 8'd26) begin
      aligned = {26'd0, |ms};
    end else begin
      wide    = {ms, 26'd0} >> d;
      aligned = {wide[49:24], wide[23] | (|wide[22:0])};
    end

    if (sl ^ ss) raw = {1'b0, ml, 3'b000} - {1'b0, aligned};
    else         raw = {1'b0, ml, 3'b000} + {1'b0, aligned};

    exp_w = {2'b00, el};

    if (raw[27]) begin
      norm  = {raw[27:2], raw[1] | raw[0]};
      exp_w = exp_w + 10'd1;
    end else begin
      for (int i = 26; i >= 0; i--) begin
        if (!found && raw[i]) found = 1'b1;
        else if (!found)      lz    = lz + 1;
      end
      // Stop normalising at exponent 1: what remains is a denormal.
      shift = (lz < int'(exp_w) - 1) ? lz : int'(exp_w) - 1;
      norm  = raw[26:0] << shift;
      exp_w = exp_w - 10'(shift);
    end

    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) begin
      sum = QNAN;
    end else if (a_inf) begin
      sum = a;
    end else if (b_inf) begin
      sum = b;
    end else if (raw == 28'd0) begin
      sum = '0;
    end else if (exp_w >= 10'd255) begin
      sum = {sl, 8'hFE, 23'h7F_FFFF};
    end else begin
      sum = {sl, norm[26] ? exp_w[7:0] : 8'd0, norm[25:3]};
    end
  end

endmodule

// File: rtl/float_add_arbiter_rr.sv
// rr_arbiter
//   Combinational round-robin arbiter. Searches req starting at ptr and
//   wrapping modulo N; the first asserted request wins.
// Ports
//   req     in   N     request vector
//   ptr     in   IDW   highest-priority index (always < N)
//   en      in   1     grant enable; gnt is all-zero when low
//   gnt     out  N     one-hot grant (zero when en=0 or no request)
//   gnt_idx out  IDW   index of the winning request (valid when any=1)
//   any     out  1     at least one request is asserted
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx,
  output logic           any
);

  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx]) begin
        any     = 1'b1;
        gnt_idx = IDW'(idx);
        gnt[idx] = en;
      end
    end
  end

endmodule

// File: rtl/float_add_arbiter.sv
// float_add_arbiter
//   Shares one combinational float_add_gc among N requesters. A round-robin
//   arbiter picks one valid requester per cycle whenever the result slot is
//   free; the chosen pair is added the same cycle and the sum is registered
//   together with the requester id.
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   req_valid  in   N      per-requester operand pair valid
//   req_ready  out  N      per-requester accept, one-hot or zero
//   req_a      in   N*32   operand A, requester i at [32*i+31:32*i]
//   req_b      in   N*32   operand B, same packing
//   res_valid  out  1      result register holds a sum
//   res_ready  in   1      downstream accepts result
//   res_sum    out  32     sum of the granted pair
//   res_id     out  IDW    requester that produced res_sum
module float_add_arbiter
  import float_add_arbiter_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  input  logic [N*FLOAT_W-1:0] req_a,
  input  logic [N*FLOAT_W-1:0] req_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [FLOAT_W-1:0]   res_sum,
  output logic [IDW-1:0]       res_id
);

  logic               res_valid_q, res_valid_d;
  logic [FLOAT_W-1:0] res_sum_q, res_sum_d;
  logic [IDW-1:0]     res_id_q, res_id_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;

  logic               slot_free;
  logic               grant;
  logic [N-1:0]       gnt;
  logic [IDW-1:0]     gnt_idx;
  logic [FLOAT_W-1:0] op_a, op_b, add_sum;

  // A slot is free when empty or when its current result leaves this cycle.
  assign slot_free = !res_valid_q || res_ready;

  rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .en      (slot_free),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (grant)
  );

  assign req_ready = gnt;

  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == IDW'(i)) begin
        op_a = req_a[FLOAT_W*i +: FLOAT_W];
        op_b = req_b[FLOAT_W*i +: FLOAT_W];
      end
    end
  end

  float_add_gc u_add (
    .a   (op_a),
    .b   (op_b),
    .sum (add_sum)
  );

  always_comb begin
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_id_d    = res_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (grant && slot_free) begin
      res_valid_d = 1'b1;
      res_sum_d   = add_sum;
      res_id_d    = gnt_idx;
      rr_ptr_d    = (gnt_idx == IDW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_id_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_id_q    <= res_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_id    = res_id_q;

endmodule
